snoop_responder: RTL

// - Responder end of the snoop bus, one instance per L1 D-cache (ooo_d, ppl_d).
// - Accepts the bus command broadcast by the snoop bus arbiter and looks it up in the local 4-way tag/state arrays.
// - Returns hit/miss plus line data, and applies the MESI state transition the command requires.
// - Shares the array port with the local cache controller through a req/gnt handshake.

---
 rtl/snoop_pkg.sv | 60 ++++++
 rtl/snoop_tag_match.sv | 33 +++
 rtl/snoop_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/snoop_pkg.sv
// Shared types and MESI transition rules for the snoop responder.
package snoop_pkg;

    localparam int unsigned WAYS    = 4;
    localparam int unsigned WAY_W   = 2;
    localparam int unsigned SETS    = 16;
    localparam int unsigned TAG_W   = 23;
    localparam int unsigned SET_W   = 4;
    localparam int unsigned OFF_W   = 5;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned ENTRY_W = 2 + TAG_W;

    typedef enum logic [1:0] {
        MesiI = 2'b00,
        MesiS = 2'b01,
        MesiE = 2'b10,
        MesiM = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        CmdNone    = 2'b00,
        CmdBusUpgr = 2'b01,
        CmdBusRd   = 2'b10,
        CmdBusRdX  = 2'b11
    } bus_cmd_t;

    typedef struct packed {
        mesi_t state;
        logic  supply;
        logic  dirty;
    } mesi_next_t;

    // Invalid lines never change; BusUpgr on E/M is illegal and leaves the line alone.
    function automatic mesi_next_t next_mesi(input bus_cmd_t cmd, input mesi_t cur);
        mesi_next_t r;
        r.state  = cur;
        r.supply = 1'b0;
        r.dirty  = 1'b0;
        if (cur != MesiI) begin
            unique case (cmd)
                CmdBusRd: begin
                    r.state  = MesiS;
                    r.supply = 1'b1;
                    r.dirty  = (cur == MesiM);
                end
                CmdBusRdX: begin
                    r.state  = MesiI;
                    r.supply = 1'b1;
                    r.dirty  = (cur == MesiM);
                end
                CmdBusUpgr: begin
                    if (cur == MesiS) r.state = MesiI;
                end
                default: ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/snoop_tag_match.sv
// Four-way tag compare with lowest-way priority; flags multiple hits.
module snoop_tag_match
    import snoop_pkg::*;
(
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [ENTRY_W-1:0] entry_i [WAYS],
    output logic               hit_o,
    output logic [WAY_W-1:0]   way_o,
    output mesi_t              state_o,
    output logic               multi_hit_o
);

    logic [WAYS-1:0] match;

    always_comb begin
        match   = '0;
        hit_o   = 1'b0;
        way_o   = '0;
        state_o = MesiI;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = (entry_i[w][TAG_W-1:0] == tag_i) && (entry_i[w][ENTRY_W-1 -: 2] != 2'b00);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_o   = 1'b1;
                way_o   = WAY_W'(w);
                state_o = mesi_t'(entry_i[w][ENTRY_W-1 -: 2]);
            end
        end
        multi_hit_o = (match & (match - 1'b1)) != '0;
    end

endmodule

// File: rtl/snoop_responder.sv
// Snoop bus responder: looks up a broadcast command in the local tag arrays and applies MESI.
module snoop_responder
    import snoop_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               bus_command_valid_i,
    input  logic [31:0]        bus_command_address_i,
    input  logic [1:0]         bus_command_command_i,
    output logic               bus_resp_valid_o,
    output logic [31:0]        bus_resp_address_o,
    output logic [1:0]         bus_resp_command_o,
    output logic [LINE_W-1:0]  bus_resp_data_o,
    output logic               bus_resp_hit_o,
    output logic               bus_resp_dirty_o,
    output logic               snoop_array_req_o,
    input  logic               snoop_array_gnt_i,
    output logic [SET_W-1:0]   snoop_set_index_o,
    input  logic [ENTRY_W-1:0] snoop_tag_in_i [WAYS],
    input  logic [LINE_W-1:0]  snoop_data_in_i [WAYS],
    output logic               snoop_tag_we_o [WAYS],
    output logic [ENTRY_W-1:0] snoop_tag_out_o [WAYS]
);

    typedef enum logic [2:0] {StIdle, StReq, StRead, StResp, StUpd, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q;
    bus_cmd_t          cmd_q;
    logic [WAY_W-1:0]  way_q;
    mesi_t             upd_state_q;
    logic              resp_valid_q, resp_hit_q, resp_dirty_q;
    logic [31:0]       resp_addr_q;
    logic [1:0]        resp_cmd_q;
    logic [LINE_W-1:0] resp_data_q;

    logic             cmd_accept;
    logic             match_hit, multi_hit, need_upd;
    logic [WAY_W-1:0] match_way;
    mesi_t            match_state;
    mesi_next_t       nx;
    logic [TAG_W-1:0] addr_tag;

    assign cmd_accept = bus_command_valid_i && (bus_cmd_t'(bus_command_command_i) != CmdNone);
    assign addr_tag   = addr_q[OFF_W+SET_W +: TAG_W];

    snoop_tag_match u_tag_match (
        .tag_i       (addr_tag),
        .entry_i     (snoop_tag_in_i),
        .hit_o       (match_hit),
        .way_o       (match_way),
        .state_o     (match_state),
        .multi_hit_o (multi_hit)
    );

    assign nx       = next_mesi(cmd_q, match_state);
    assign need_upd = match_hit && (nx.state != match_state);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_accept) state_d = StReq;
            StReq:   if (snoop_array_gnt_i) state_d = StRead;
            StRead:  state_d = StResp;
            StResp:  state_d = need_upd ? StUpd : StDone;
            StUpd:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reset gates the port signals combinationally so an abort releases the array at once.
    always_comb begin
        snoop_array_req_o = !rst_i && (state_q inside {StReq, StRead, StResp, StUpd});
        snoop_set_index_o = snoop_array_req_o ? addr_q[OFF_W +: SET_W] : '0;
        for (int w = 0; w < WAYS; w++) begin
            snoop_tag_we_o[w]  = !rst_i && (state_q == StUpd) && (way_q == WAY_W'(w));
            snoop_tag_out_o[w] = (state_q == StUpd) ? {upd_state_q, addr_tag} : '0;
        end
        bus_resp_valid_o   = resp_valid_q;
        bus_resp_address_o = resp_addr_q;
        bus_resp_command_o = resp_cmd_q;
        bus_resp_data_o    = resp_data_q;
        bus_resp_hit_o     = resp_hit_q;
        bus_resp_dirty_o   = resp_dirty_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            cmd_q        <= CmdNone;
            way_q        <= '0;
            upd_state_q  <= MesiI;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_cmd_q   <= '0;
            resp_data_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_dirty_q <= 1'b0;
        end else begin
            resp_valid_q <= (state_q == StResp);
            if (state_q == StIdle && cmd_accept) begin
                addr_q <= bus_command_address_i;
                cmd_q  <= bus_cmd_t'(bus_command_command_i);
            end
            if (state_q == StResp) begin
                resp_addr_q  <= addr_q;
                resp_cmd_q   <= cmd_q;
                resp_hit_q   <= match_hit;
                resp_dirty_q <= match_hit && nx.dirty;
                resp_data_q  <= (match_hit && nx.supply) ? snoop_data_in_i[match_way] : '0;
                way_q        <= match_way;
                upd_state_q  <= nx.state;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(bus_command_valid_i && state_q != StIdle))
                else $warning("snoop_responder: bus command while busy, ignored");
            assert (!(state_q == StResp && multi_hit))
                else $error("snoop_responder: multiple ways hit");
            assert (!(state_q == StResp && match_hit && cmd_q == CmdBusUpgr &&
                      match_state inside {MesiE, MesiM}))
                else $error("snoop_responder: BusUpgr on exclusive line");
        end
    end

endmodule
